// File: rtl/two_of_five_pkg.sv
// Shared constants and types for the 2-out-of-5 key matrix scanner and decoder.
// Column weights, row count, scan FSM states and the idle row-drive pattern.
package two_of_five_pkg;

    localparam int NUM_ROWS = 7;

    localparam logic [3:0] COL_W4 = 4'd7;
    localparam logic [3:0] COL_W3 = 4'd4;
    localparam logic [3:0] COL_W2 = 4'd2;
    localparam logic [3:0] COL_W1 = 4'd1;
    localparam logic [3:0] COL_W0 = 4'd0;

    localparam logic [6:0] ROWS_IDLE = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_t;

    // Active-low one-hot drive for a 1-based row number.
    function automatic logic [6:0] row_drive(input logic [2:0] row_num);
        return ~(7'd1 << (row_num - 3'd1));
    endfunction

endpackage

// File: rtl/two_of_five_decode.sv
// Combinational 2-out-of-5 decoder: digit is the sum of column weights, 7+4 reads as 0.
// ok is set only for the ten two-bit patterns; digit is 4'hF otherwise.
module two_of_five_decode
    import two_of_five_pkg::*;
(
    input  logic [4:0] col_i,
    output logic [3:0] digit_o,
    output logic       ok_o
);

    logic [3:0] sum;
    logic [2:0] ones;

    always_comb begin
        sum = (col_i[4] ? COL_W4 : 4'd0) + (col_i[3] ? COL_W3 : 4'd0)
            + (col_i[2] ? COL_W2 : 4'd0) + (col_i[1] ? COL_W1 : 4'd0)
            + (col_i[0] ? COL_W0 : 4'd0);
        ones = {2'b0, col_i[4]} + {2'b0, col_i[3]} + {2'b0, col_i[2]}
             + {2'b0, col_i[1]} + {2'b0, col_i[0]};
        ok_o = (ones == 3'd2);
        if (!ok_o)
            digit_o = 4'hF;
        else if (sum == 4'd11)
            digit_o = 4'd0;
        else
            digit_o = sum;
    end

endmodule

// File: rtl/matrix_scanner.sv
// Row-strobing 2-of-5 matrix receiver with per-row debounce; one valid/err pulse per stable press.
// Event pulse lands on the GAP cycle right after the row's last DRIVE-cycle sample.
module matrix_scanner
    import two_of_five_pkg::*;
#(
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] col,
    output logic [6:0] r,
    output logic       l,
    output logic [2:0] row,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    scan_state_t   state_q;
    logic [DW-1:0] dwell_q;
    logic [2:0]    row_cnt_q;
    logic [6:0]    r_q;
    logic          l_q;
    logic [2:0]    row_q;
    logic [3:0]    digit_q;
    logic          valid_q;
    logic          err_q;

    logic [4:0]    hist_pat_q [NUM_ROWS];
    logic [CW-1:0] hist_cnt_q [NUM_ROWS];
    logic          hist_rep_q [NUM_ROWS];

    logic [2:0]    idx;
    logic [2:0]    row_nxt;
    logic          hit;
    logic [CW-1:0] cnt_d;
    logic          rep_d;
    logic          report;
    logic [3:0]    dec_digit;
    logic          dec_ok;

    two_of_five_decode u_decode (
        .col_i   (col),
        .digit_o (dec_digit),
        .ok_o    (dec_ok)
    );

    // History update for the row being sampled; only committed on the last DRIVE cycle.
    always_comb begin
        idx     = row_cnt_q - 3'd1;
        row_nxt = (row_cnt_q == 3'd7) ? 3'd1 : row_cnt_q + 3'd1;
        hit     = (col == hist_pat_q[idx]);
        if (!hit)
            cnt_d = CW'(1);
        else if (hist_cnt_q[idx] == CW'(DEBOUNCE))
            cnt_d = hist_cnt_q[idx];
        else
            cnt_d = hist_cnt_q[idx] + CW'(1);
        rep_d  = hit ? hist_rep_q[idx] : 1'b0;
        report = (cnt_d == CW'(DEBOUNCE)) && !rep_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dwell_q   <= '0;
            row_cnt_q <= 3'd1;
            r_q       <= ROWS_IDLE;
            l_q       <= 1'b0;
            row_q     <= 3'd0;
            digit_q   <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                hist_pat_q[i] <= '0;
                hist_cnt_q[i] <= '0;
                hist_rep_q[i] <= 1'b0;
            end
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!en) begin
                state_q   <= ST_IDLE;
                dwell_q   <= '0;
                row_cnt_q <= 3'd1;
                r_q       <= ROWS_IDLE;
                l_q       <= 1'b0;
                for (int i = 0; i < NUM_ROWS; i++) begin
                    hist_pat_q[i] <= '0;
                    hist_cnt_q[i] <= '0;
                    hist_rep_q[i] <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_DRIVE;
                        dwell_q <= '0;
                        r_q     <= row_drive(row_cnt_q);
                        l_q     <= 1'b1;
                    end
                    ST_DRIVE: begin
                        if (dwell_q == DW'(DWELL - 1)) begin
                            state_q         <= ST_GAP;
                            r_q             <= ROWS_IDLE;
                            hist_pat_q[idx] <= col;
                            hist_cnt_q[idx] <= cnt_d;
                            hist_rep_q[idx] <= rep_d | report;
                            // A stable all-zero pattern is a release and stays silent.
                            if (report && (col != 5'b00000)) begin
                                row_q   <= row_cnt_q;
                                digit_q <= dec_ok ? dec_digit : 4'hF;
                                valid_q <= dec_ok;
                                err_q   <= !dec_ok;
                            end
                        end else begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                    ST_GAP: begin
                        state_q   <= ST_DRIVE;
                        dwell_q   <= '0;
                        row_cnt_q <= row_nxt;
                        r_q       <= row_drive(row_nxt);
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        r_q     <= ROWS_IDLE;
                        l_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign r     = r_q;
    assign l     = l_q;
    assign row   = row_q;
    assign digit = digit_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
